// File: rtl/pc_sequencer.sv
// Next-PC controller for the MIPS fetch stage: selects sequential/branch/jump/exception PC and runs the imem handshake.
// Optional misaligned-redirect trap compiled in with `define PC_ALIGN_CHECK_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter int          MAX_WAIT   = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_exc,
  input  logic        i_imem_ack,
  output logic [31:0] o_pc,
  output logic        o_imem_req,
  output logic        o_fetch_valid,
  output logic        o_timeout,
  output logic        o_misalign
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [1:0]  state;
  logic [7:0]  wait_cnt;
  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] redirect_pc;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  assign redirect   = i_exc | i_jump | i_branch_taken;
  assign raw_target = i_jump ? i_jump_target : i_branch_target;

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned;
  logic misalign_q;

  // Exception vector is trusted; only branch/jump targets are checked.
  assign misaligned  = redirect && !i_exc && (raw_target[1:0] != 2'b00);
  assign redirect_pc = (i_exc || misaligned) ? EXC_VECTOR : raw_target;

  always_ff @(posedge i_clk) begin
    if (i_rst_n)
      misalign_q <= 1'b0;
    else
      misalign_q <= misaligned && ((state == S_FETCH) || (state == S_STALL));
  end

  assign o_misalign = misalign_q;
`else
  logic unused_target_bits;

  assign unused_target_bits = ^raw_target[1:0];
  assign redirect_pc        = i_exc ? EXC_VECTOR : {raw_target[31:2], 2'b00};
  assign o_misalign         = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      state         <= S_BOOT;
      o_pc          <= RESET_PC;
      o_imem_req    <= 1'b0;
      o_fetch_valid <= 1'b0;
      o_timeout     <= 1'b0;
      wait_cnt      <= 8'd0;
    end else begin
      o_fetch_valid <= 1'b0;
      case (state)
        S_BOOT: begin
          state      <= S_FETCH;
          o_imem_req <= 1'b1;
        end
        S_FETCH: begin
          // A redirect flushes whatever fetch completes in the same cycle.
          if (redirect) begin
            o_pc     <= redirect_pc;
            wait_cnt <= 8'd0;
          end else if (i_imem_ack) begin
            o_pc          <= seq_pc(o_pc);
            o_fetch_valid <= 1'b1;
            wait_cnt      <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
          if (i_stall) begin
            state      <= S_STALL;
            o_imem_req <= 1'b0;
            wait_cnt   <= 8'd0;
          end else if (!redirect && !i_imem_ack && (wait_cnt == WAIT_LAST)) begin
            state      <= S_ERROR;
            o_imem_req <= 1'b0;
            o_timeout  <= 1'b1;
            wait_cnt   <= 8'd0;
          end
        end
        S_STALL: begin
          if (redirect)
            o_pc <= redirect_pc;
          if (!i_stall) begin
            state      <= S_FETCH;
            o_imem_req <= 1'b1;
          end
        end
        S_ERROR: begin
          if (i_exc) begin
            o_pc       <= EXC_VECTOR;
            o_timeout  <= 1'b0;
            state      <= i_stall ? S_STALL : S_FETCH;
            o_imem_req <= !i_stall;
          end
        end
        default: begin
          state      <= S_BOOT;
          o_imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the MIPS fetch stage.
- Owns the program counter value and selects the next PC from four sources: sequential, branch, jump, exception.
- Runs a request/acknowledge handshake with instruction memory.
- Handles pipeline stall, fetch abort on redirect, and fetch timeout.
- Its o_pc drives the i_pc input of the PC register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, PC loaded on exception (and on misalign, when the optional feature is compiled in).
- MAX_WAIT, 15, cycles without i_imem_ack before timeout; range 1..255.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst_n  input  1  synchronous reset, active-high (1 = reset).
- i_stall  input  1  hold fetch; PC frozen unless redirected.
- i_branch_taken  input  1  branch redirect request.
- i_branch_target  input  32  branch target address.
- i_jump  input  1  jump redirect request.
- i_jump_target  input  32  jump target address.
- i_exc  input  1  exception redirect to EXC_VECTOR.
- i_imem_ack  input  1  instruction memory accepted/returned fetch at o_pc.
- o_pc  output  32  current fetch address (registered).
- o_imem_req  output  1  fetch request at o_pc (registered).
- o_fetch_valid  output  1  one-cycle pulse: fetch at the previous o_pc completed and is not flushed.
- o_timeout  output  1  sticky fetch timeout flag.
- o_misalign  output  1  one-cycle pulse, misaligned redirect target (optional feature only).

Behaviour:
- Reset: on a posedge with i_rst_n=1, the block loads o_pc=RESET_PC, o_imem_req=0, o_fetch_valid=0, o_timeout=0, o_misalign=0, wait_cnt=0, state=BOOT. Reset overrides every other input.
- States: BOOT, FETCH, STALL, ERROR.
- BOOT: after one cycle, go to FETCH with o_imem_req=1. The first request is issued 1 cycle after reset is released. Redirects are ignored in BOOT.
- Redirect priority: i_exc > i_jump > i_branch_taken > sequential (o_pc+4, 32-bit wrap, 32'hFFFF_FFFC -> 0).
- FETCH, ack with no redirect: o_pc <= o_pc+4, o_fetch_valid=1 next cycle, wait_cnt <= 0.
- FETCH, ack and redirect in the same cycle: o_pc <= target, o_fetch_valid=0 (fetch flushed), wait_cnt <= 0.
- FETCH, no ack but redirect: o_pc <= target. The outstanding fetch is abandoned, o_imem_req stays 1, wait_cnt <= 0.
- FETCH, no ack and no redirect: wait_cnt++. When wait_cnt reaches MAX_WAIT-1 without ack, go to ERROR next cycle with o_imem_req=0 and o_timeout=1.
- FETCH, i_stall=1: ack/redirect handling above applies in the same cycle. State then goes to STALL and o_imem_req=0 next cycle.
- STALL: i_imem_ack is ignored; o_pc is held; wait_cnt is frozen at 0. Redirects still update o_pc by priority. When i_stall=0, go to FETCH with o_imem_req=1 next cycle.
- ERROR: o_pc held, o_imem_req=0. Only reset or i_exc leaves ERROR. i_exc sets o_pc=EXC_VECTOR, clears o_timeout, and goes to FETCH (or STALL if i_stall=1).
- o_fetch_valid is never high for 2 cycles unless acks arrive on consecutive cycles.
- Latency: ack to next-address request is 1 cycle, so back-to-back acks sustain 1 fetch/cycle.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined: any accepted redirect target with bits [1:0] != 0 loads EXC_VECTOR instead of the target and pulses o_misalign for 1 cycle. i_exc targets are never checked.
- Undefined: target bits [1:0] are forced to 00, o_misalign is tied 0, and no extra logic is generated.

Test Plan:
- Reset release, ack held 1 → o_imem_req=1 at cycle 1; o_pc 0,4,8,12; o_fetch_valid high from cycle 2.
- o_pc=0x40 in FETCH, i_jump=1 target 0x100 with ack same cycle → o_fetch_valid=0, o_pc=0x100, next ack gives o_pc=0x104.
- i_exc=1, i_jump=1, i_branch_taken=1 together → o_pc=EXC_VECTOR (0x80).
- MAX_WAIT=4, ack held 0 → o_timeout=1 and o_imem_req=0 after 4 request cycles; then i_exc=1 → o_pc=0x80, o_timeout=0, o_imem_req=1.
- i_stall=1 for 3 cycles at o_pc=0x20, ack toggling → o_pc held at 0x20, no o_fetch_valid; stall released → request resumes at 0x20. Branch to 0x200 during stall → resumes at 0x200.
- With PC_ALIGN_CHECK_EN: branch target 0x102 → o_pc=0x80, o_misalign pulses once. Without it: same branch → o_pc=0x100.
